// File: rtl/aes_byte_loader.sv
// aes_byte_loader: gathers byte-serial key and plaintext streams into a full AES key and 128-bit block
module aes_byte_loader #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         k_valid,
    input  logic [7:0]   k_data,
    output logic         k_ready,
    input  logic         d_valid,
    input  logic [7:0]   d_data,
    output logic         d_ready,
    output logic         key_valid,
    output logic [N-1:0] key_out,
    output logic [127:0] block_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  blk_count
);
    localparam int KB = N / 8;
    localparam int KW = $clog2(KB);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    logic [KW-1:0] kcnt;
    logic [4:0]    dcnt;
    logic          k_acc, d_acc, k_start, done;

    // readies drop in reset, while presenting, without a full key, or once the block is full
    always_comb begin
        k_ready = rst_n && state == FILL;
        d_ready = k_ready && key_valid && dcnt != 5'd16;
        k_acc   = k_valid && k_ready;
        d_acc   = d_valid && d_ready;
        k_start = k_acc && kcnt == '0;
        done    = !k_start && ((d_acc && dcnt == 5'd15) || (state == FILL && dcnt == 5'd16 && key_valid));
    end

    // key/block assembly and FILL/HOLD sequencing; a block finishing as a key reload starts waits at dcnt==16
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            kcnt      <= '0;
            dcnt      <= '0;
            key_valid <= 1'b0;
            key_out   <= '0;
            block_out <= '0;
            out_valid <= 1'b0;
            blk_count <= '0;
        end else begin
            if (k_acc) begin
                key_out[N-1-8*kcnt -: 8] <= k_data;
                kcnt <= (kcnt == KW'(KB-1)) ? '0 : kcnt + 1'b1;
                if (kcnt == KW'(KB-1))
                    key_valid <= 1'b1;
                else if (kcnt == '0)
                    key_valid <= 1'b0;
            end
            if (d_acc) begin
                block_out[127-8*dcnt -: 8] <= d_data;
                dcnt <= dcnt + 1'b1;
            end
            if (done) begin
                dcnt      <= '0;
                state     <= HOLD;
                out_valid <= 1'b1;
            end
            if (out_valid && out_ready) begin
                state     <= FILL;
                out_valid <= 1'b0;
                blk_count <= blk_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_byte_loader.sv
// tb_aes_byte_loader: directed checks of the byte loader at N=128, 256 and 192
module tb_aes_byte_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   k_data = '0;
    logic [7:0]   d_data = '0;
    logic         out_ready = 1'b0;
    logic         k_vld [3];
    logic         d_vld [3];
    logic         k_rdy [3];
    logic         d_rdy [3];
    logic         kv [3];
    logic         ov [3];
    logic [127:0] blk [3];
    logic [15:0]  cnt [3];
    logic [127:0] key0;
    logic [255:0] key1;
    logic [191:0] key2;
    int           pass = 0;
    int           total = 0;

    always #5 clk = ~clk;

    aes_byte_loader #(.N(128)) u0 (.clk(clk), .rst_n(rst_n), .k_valid(k_vld[0]), .k_data(k_data), .k_ready(k_rdy[0]),
        .d_valid(d_vld[0]), .d_data(d_data), .d_ready(d_rdy[0]), .key_valid(kv[0]), .key_out(key0),
        .block_out(blk[0]), .out_valid(ov[0]), .out_ready(out_ready), .blk_count(cnt[0]));
    aes_byte_loader #(.N(256)) u1 (.clk(clk), .rst_n(rst_n), .k_valid(k_vld[1]), .k_data(k_data), .k_ready(k_rdy[1]),
        .d_valid(d_vld[1]), .d_data(d_data), .d_ready(d_rdy[1]), .key_valid(kv[1]), .key_out(key1),
        .block_out(blk[1]), .out_valid(ov[1]), .out_ready(out_ready), .blk_count(cnt[1]));
    aes_byte_loader #(.N(192)) u2 (.clk(clk), .rst_n(rst_n), .k_valid(k_vld[2]), .k_data(k_data), .k_ready(k_rdy[2]),
        .d_valid(d_vld[2]), .d_data(d_data), .d_ready(d_rdy[2]), .key_valid(kv[2]), .key_out(key2),
        .block_out(blk[2]), .out_valid(ov[2]), .out_ready(out_ready), .blk_count(cnt[2]));

    typedef struct {
        logic         ld;
        logic [127:0] key;
        logic [127:0] blk;
        logic [127:0] exp_key;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass++;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            k_vld[s] = 1'b0;
            d_vld[s] = 1'b0;
        end
        tick;
        tick;
        rst_n = 1'b1;
        #1;
    endtask

    // key is left-justified in 256 bits; byte i is the i-th byte streamed
    task automatic send_key(input int s, input logic [255:0] k, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            k_vld[s] = 1'b1;
            k_data = k[255-8*i -: 8];
            tick;
        end
        k_vld[s] = 1'b0;
    endtask

    task automatic send_blk(input int s, input logic [127:0] b, input int first, input int last);
        int i = first;
        int n = 0;
        logic acc;
        while (i <= last && n < 300) begin
            d_vld[s] = 1'b1;
            d_data = b[127-8*i -: 8];
            acc = d_rdy[s];
            tick;
            if (acc) i++;
            n++;
        end
        d_vld[s] = 1'b0;
        if (i <= last) chk("blk_timeout", 256'(i), 256'(last + 1));
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 16'd1};
        vecs[1] = '{1'b0, 128'h0, 128'h00112233445566778899aabbccddeeff,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 16'd2};
        vecs[2] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h000102030405060708090a0b0c0d0e0f, 16'd3};
        for (int s = 0; s < 3; s++) begin
            k_vld[s] = 1'b0;
            d_vld[s] = 1'b0;
        end
        tick;
        chk("rst_k_ready", 256'(k_rdy[0]), 256'(0));
        chk("rst_d_ready", 256'(d_rdy[0]), 256'(0));
        do_reset;
        chk("rst_out_valid", 256'(ov[0]), 256'(0));
        chk("rst_key_valid", 256'(kv[0]), 256'(0));
        chk("rst_key_out", 256'(key0), 256'(0));
        chk("rst_block_out", 256'(blk[0]), 256'(0));
        chk("rst_blk_count", 256'(cnt[0]), 256'(0));
        chk("rst_k_ready_run", 256'(k_rdy[0]), 256'(1));
        chk("rst_d_ready_nokey", 256'(d_rdy[0]), 256'(0));

        for (int v = 0; v < 3; v++) begin
            if (vecs[v].ld) begin
                send_key(0, {vecs[v].key, 128'h0}, 0, 15);
                chk("v_key_valid", 256'(kv[0]), 256'(1));
            end
            send_blk(0, vecs[v].blk, 0, 14);
            chk("v_ov_early", 256'(ov[0]), 256'(0));
            send_blk(0, vecs[v].blk, 15, 15);
            chk("v_out_valid", 256'(ov[0]), 256'(1));
            chk("v_key_out", 256'(key0), 256'(vecs[v].exp_key));
            chk("v_block_out", 256'(blk[0]), 256'(vecs[v].blk));
            chk("v_k_ready_hold", 256'(k_rdy[0]), 256'(0));
            chk("v_d_ready_hold", 256'(d_rdy[0]), 256'(0));
            handshake;
            chk("v_ov_cleared", 256'(ov[0]), 256'(0));
            chk("v_blk_count", 256'(cnt[0]), 256'(vecs[v].exp_cnt));
        end

        do_reset;
        send_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, 15);
        chk("k256_not_at_16", 256'(kv[1]), 256'(0));
        send_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 16, 31);
        chk("k256_at_32", 256'(kv[1]), 256'(1));
        send_blk(1, 128'h00112233445566778899aabbccddeeff, 0, 15);
        chk("k256_out_valid", 256'(ov[1]), 256'(1));
        chk("k256_key_out", 256'(key1), 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        chk("k256_block_out", 256'(blk[1]), 256'(128'h00112233445566778899aabbccddeeff));

        do_reset;
        d_vld[0] = 1'b1;
        d_data = 8'h32;
        send_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 15);
        chk("early_d_not_taken", 256'(blk[0]), 256'(0));
        chk("early_d_ready_now", 256'(d_rdy[0]), 256'(1));
        send_blk(0, 128'h3243f6a8885a308d313198a2e0370734, 0, 15);
        chk("early_block_out", 256'(blk[0]), 256'(128'h3243f6a8885a308d313198a2e0370734));
        for (int i = 0; i < 5; i++) begin
            d_vld[0] = 1'b1;
            d_data = 8'(8'h50 + 8'(i * 7));
            tick;
        end
        d_vld[0] = 1'b0;
        chk("hold_block_stable", 256'(blk[0]), 256'(128'h3243f6a8885a308d313198a2e0370734));
        chk("hold_out_valid", 256'(ov[0]), 256'(1));
        handshake;
        chk("hs_blk_count", 256'(cnt[0]), 256'(1));
        chk("hs_out_valid", 256'(ov[0]), 256'(0));
        chk("hs_d_ready", 256'(d_rdy[0]), 256'(1));

        send_blk(0, 128'h6bc1bee22e409f96e93d7e117393172a, 0, 14);
        k_vld[0] = 1'b1;
        k_data = 8'h00;
        d_vld[0] = 1'b1;
        d_data = 8'h2a;
        tick;
        k_vld[0] = 1'b0;
        d_vld[0] = 1'b0;
        chk("defer_ov", 256'(ov[0]), 256'(0));
        chk("defer_d_ready", 256'(d_rdy[0]), 256'(0));
        chk("defer_key_valid", 256'(kv[0]), 256'(0));
        send_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1, 15);
        chk("defer_ov_keydone", 256'(ov[0]), 256'(0));
        tick;
        chk("defer_ov_late", 256'(ov[0]), 256'(1));
        chk("defer_block_out", 256'(blk[0]), 256'(128'h6bc1bee22e409f96e93d7e117393172a));
        chk("defer_key_out", 256'(key0), 256'(128'h000102030405060708090a0b0c0d0e0f));

        force u0.blk_count = 16'hffff;
        tick;
        release u0.blk_count;
        handshake;
        chk("wrap_blk_count", 256'(cnt[0]), 256'(0));

        send_blk(0, 128'h00112233445566778899aabbccddeeff, 0, 15);
        chk("pre_rst_hold", 256'(ov[0]), 256'(1));
        rst_n = 1'b0;
        tick;
        chk("hrst_k_ready", 256'(k_rdy[0]), 256'(0));
        chk("hrst_out_valid", 256'(ov[0]), 256'(0));
        chk("hrst_key_valid", 256'(kv[0]), 256'(0));
        chk("hrst_key_out", 256'(key0), 256'(0));
        chk("hrst_block_out", 256'(blk[0]), 256'(0));
        rst_n = 1'b1;
        #1;
        chk("hrst_fill", 256'(k_rdy[0]), 256'(1));

        do_reset;
        send_key(2, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, 23);
        send_blk(2, 128'h00112233445566778899aabbccddeeff, 0, 7);
        send_key(2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 0, 0);
        chk("rl_key_valid", 256'(kv[2]), 256'(0));
        chk("rl_d_ready", 256'(d_rdy[2]), 256'(0));
        send_key(2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1, 23);
        chk("rl_key_done", 256'(kv[2]), 256'(1));
        send_blk(2, 128'h00112233445566778899aabbccddeeff, 8, 15);
        chk("rl_out_valid", 256'(ov[2]), 256'(1));
        chk("rl_block_out", 256'(blk[2]), 256'(128'h00112233445566778899aabbccddeeff));
        chk("rl_key_out", 256'(key2), 256'(192'h000102030405060708090a0b0c0d0e0f1011121314151617));

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/aes_byte_loader.md
Name: aes_byte_loader

Overview:
- Upstream feeder for the combinational AES_Encrypt core.
- Collects a byte-serial key stream and a byte-serial plaintext stream, and presents a complete key and a complete 128-bit block together, with a valid/ready handshake.
- key_out and block_out connect directly to the AES_Encrypt key and input ports, using the same N parameter.
- The key is retained across blocks and is reloaded only when new key bytes arrive.

Parameters:
- N, 128, key length in bits; legal values are 128, 192 and 256, matching AES_Encrypt's N.
- KB, N/8, key byte count (derived, not overridable).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- k_valid  in  1  key byte valid.
- k_data  in  8  key byte; the first byte received lands in key_out[N-1:N-8].
- k_ready  out  1  key byte accepted when k_valid && k_ready.
- d_valid  in  1  plaintext byte valid.
- d_data  in  8  plaintext byte; the first byte received lands in block_out[127:120].
- d_ready  out  1  plaintext byte accepted when d_valid && d_ready.
- key_valid  out  1  a complete key of KB bytes is loaded.
- key_out  out  N  assembled key.
- block_out  out  128  assembled plaintext block.
- out_valid  out  1  key_out and block_out are presented.
- out_ready  in  1  downstream accepts the presented pair.
- blk_count  out  16  number of completed output handshakes; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid, key_valid, key_out, block_out, blk_count, and the internal key and data byte counters all clear to 0.
  - State goes to FILL.
  - k_ready and d_ready read 0 while rst_n=0.
  - Reset mid-fill or mid-HOLD discards all partial or presented data; no handshake completes in that cycle.
- States: FILL, HOLD.
- FILL:
  - k_ready=1.
  - d_ready=key_valid (registered value).
- HOLD:
  - k_ready=0, d_ready=0, out_valid=1.
  - key_out and block_out are stable.
- Key path (k_valid && k_ready):
  - key_out[N-1-8*kcnt -: 8] <= k_data.
  - kcnt increments; at kcnt==KB-1 it wraps to 0 and key_valid <= 1.
  - Accepting a byte with kcnt==0 clears key_valid in the same edge, unless KB==1 (never, since KB>=16). An in-progress key reload therefore blocks plaintext from the next cycle.
- Data path (d_valid && d_ready):
  - block_out[127-8*dcnt -: 8] <= d_data.
  - dcnt increments.
  - On the byte with dcnt==15: dcnt <= 0, state <= HOLD, out_valid <= 1 (visible the next cycle).
- Simultaneous key and data accept in one cycle is legal. Both bytes are written.
  - If the key byte starts a new key (kcnt==0), the data byte is still accepted, because d_ready was already 1.
  - Further data stalls until the new key completes.
  - A data block completes only when key_valid=1.
  - The 16th data byte cannot coincide with the first byte of a key reload unless key_valid was 1 at the start of that cycle. In that case the transition to HOLD is deferred: the state stays FILL with dcnt=16 (full) until key_valid returns to 1, then moves to HOLD. So dcnt is 5 bits, and "full" means dcnt==16.
- A partial plaintext block survives a key reload and resumes afterwards.
- HOLD exit: when out_valid && out_ready:
  - next cycle state=FILL, out_valid=0, blk_count+1.
  - block_out keeps its old value until overwritten.
  - There is no same-cycle bypass, so the minimum interval between presented blocks is 17 cycles (16 bytes plus 1 handoff).
- out_ready while out_valid=0 is ignored.
- Latency: out_valid rises on the cycle after the 16th data byte is accepted, given key_valid=1.

Test Plan:
- Reset, then stream key 2b7e1516_28aed2a6_abf71588_09cf4f3c (16 cycles), then data 3243f6a8_885a308d_313198a2_e0370734 (16 cycles), with out_ready=0 → out_valid=1 exactly one cycle after the last d byte, key_out and block_out equal the streams, and d_ready=k_ready=0. Downstream AES_Encrypt output must be 3925841d_02dc09fb_dc118597_196a0b32.
- N=256 instance: key 00010203…1c1d1e1f over 32 bytes, data 00112233_44556677_8899aabb_ccddeeff → key_valid rises after the 32nd byte, not the 16th; the AES output is 8ea2b7ca_516745bf_eafc4990_4b496089.
- Data bytes offered before the key is complete → d_ready=0 and no bytes are captured. Then complete the key → capture starts from the first offered byte.
- Hold out_ready=0 for 5 cycles with d_valid=1 and changing d_data → block_out is unchanged. Then out_ready=1 for 1 cycle → blk_count=1, out_valid=0, d_ready=1 the next cycle.
- Load 8 data bytes, start a new N=192 key (24 bytes) → key_valid=0 and d_ready=0 during the reload. After the reload the remaining 8 bytes complete the block, containing the original first 8 bytes plus the new key.
- Assert rst_n=0 for one cycle while in HOLD → all outputs 0 and state FILL. blk_count of 0xFFFF plus one handshake → 0x0000.
